// File: rtl/jtag_tap_responder_if.sv
// Pin-side JTAG signals of the TAP responder plus the configuration outputs.
// The host (master) drives TMS/TDI; the responder (slave) drives TDO and confreg.
interface jtag_tap_responder_if #(
    parameter int CONFREG_WIDTH = 9
);
    logic                     jtag_tms_i;
    logic                     jtag_tdi_i;
    logic                     jtag_tdo_o;
    logic                     jtag_tdo_en_o;
    logic [CONFREG_WIDTH-1:0] confreg_o;
    logic                     confreg_upd_o;

    modport master (
        output jtag_tms_i, jtag_tdi_i,
        input  jtag_tdo_o, jtag_tdo_en_o, confreg_o, confreg_upd_o
    );

    modport slave (
        input  jtag_tms_i, jtag_tdi_i,
        output jtag_tdo_o, jtag_tdo_en_o, confreg_o, confreg_upd_o
    );
endinterface

// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP controller with IR, IDCODE, BYPASS and CONFREG data registers.
// Everything is clocked by TCK; TDO is launched on the falling edge.
module jtag_tap_responder #(
    parameter int                     IR_WIDTH      = 5,
    parameter logic [31:0]            IDCODE_VALUE  = 32'h249511C3,
    parameter int                     CONFREG_WIDTH = 9,
    parameter logic [IR_WIDTH-1:0]    OP_IDCODE     = 5'b00001,
    parameter logic [IR_WIDTH-1:0]    OP_CONFREG    = 5'b00110,
    parameter logic [IR_WIDTH-1:0]    OP_BYPASS     = 5'b11111
) (
    input  logic                  jtag_tck_i,
    input  logic                  jtag_trst_ni,
    jtag_tap_responder_if.slave   bus
);

    typedef enum logic [3:0] {
        S_TLR, S_RTI,
        S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAUSE_DR, S_EX2_DR, S_UPD_DR,
        S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAUSE_IR, S_EX2_IR, S_UPD_IR
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [IR_WIDTH-1:0]       r_ir;
    logic [IR_WIDTH-1:0]       r_ir_sr;
    logic [31:0]               r_id_sr;
    logic                      r_bp_sr;
    logic [CONFREG_WIDTH-1:0]  r_cfg_sr;
    logic [CONFREG_WIDTH-1:0]  r_confreg;
    logic                      r_confreg_upd;
    logic                      r_tdo;
    logic                      r_tdo_en;
    logic                      w_sel_id;
    logic                      w_sel_cfg;
    logic                      w_sel_bp;
    logic                      w_tdo;
    logic                      w_tdi;
    logic                      w_tms;

    assign w_tms = bus.jtag_tms_i;
    assign w_tdi = bus.jtag_tdi_i;

    always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) r_state <= S_TLR;
        else               r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_TLR:      w_next = w_tms ? S_TLR    : S_RTI;
            S_RTI:      w_next = w_tms ? S_SEL_DR : S_RTI;
            S_SEL_DR:   w_next = w_tms ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR:   w_next = w_tms ? S_EX1_DR : S_SH_DR;
            S_SH_DR:    w_next = w_tms ? S_EX1_DR : S_SH_DR;
            S_EX1_DR:   w_next = w_tms ? S_UPD_DR : S_PAUSE_DR;
            S_PAUSE_DR: w_next = w_tms ? S_EX2_DR : S_PAUSE_DR;
            S_EX2_DR:   w_next = w_tms ? S_UPD_DR : S_SH_DR;
            S_UPD_DR:   w_next = w_tms ? S_SEL_DR : S_RTI;
            S_SEL_IR:   w_next = w_tms ? S_TLR    : S_CAP_IR;
            S_CAP_IR:   w_next = w_tms ? S_EX1_IR : S_SH_IR;
            S_SH_IR:    w_next = w_tms ? S_EX1_IR : S_SH_IR;
            S_EX1_IR:   w_next = w_tms ? S_UPD_IR : S_PAUSE_IR;
            S_PAUSE_IR: w_next = w_tms ? S_EX2_IR : S_PAUSE_IR;
            S_EX2_IR:   w_next = w_tms ? S_UPD_IR : S_SH_IR;
            S_UPD_IR:   w_next = w_tms ? S_SEL_DR : S_RTI;
            default:    w_next = S_TLR;
        endcase
    end

    // Any opcode that is neither IDCODE nor CONFREG falls back to BYPASS.
    assign w_sel_id  = (r_ir == OP_IDCODE);
    assign w_sel_cfg = (r_ir == OP_CONFREG);
    assign w_sel_bp  = (r_ir == OP_BYPASS) || !(w_sel_id || w_sel_cfg);

    always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) begin
            r_ir    <= OP_IDCODE;
            r_ir_sr <= '0;
        end else begin
            if (r_state == S_CAP_IR)
                r_ir_sr <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
            else if (r_state == S_SH_IR)
                r_ir_sr <= {w_tdi, r_ir_sr[IR_WIDTH-1:1]};

            if (w_next == S_TLR)
                r_ir <= OP_IDCODE;
            else if (w_next == S_UPD_IR)
                r_ir <= r_ir_sr;
        end
    end

    always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) begin
            r_id_sr  <= '0;
            r_bp_sr  <= 1'b0;
            r_cfg_sr <= '0;
        end else if (r_state == S_CAP_DR) begin
            if (w_sel_id)  r_id_sr  <= IDCODE_VALUE;
            if (w_sel_cfg) r_cfg_sr <= r_confreg;
            if (w_sel_bp)  r_bp_sr  <= 1'b0;
        end else if (r_state == S_SH_DR) begin
            if (w_sel_id)  r_id_sr  <= {w_tdi, r_id_sr[31:1]};
            if (w_sel_cfg) r_cfg_sr <= {w_tdi, r_cfg_sr[CONFREG_WIDTH-1:1]};
            if (w_sel_bp)  r_bp_sr  <= w_tdi;
        end
    end

    // confreg is written on the edge entering Update-DR; a soft TLR never clears it.
    always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) begin
            r_confreg     <= '0;
            r_confreg_upd <= 1'b0;
        end else begin
            r_confreg_upd <= 1'b0;
            if (w_next == S_UPD_DR && w_sel_cfg) begin
                r_confreg     <= r_cfg_sr;
                r_confreg_upd <= 1'b1;
            end
        end
    end

    always_comb begin
        w_tdo = 1'b0;
        if (r_state == S_SH_IR)
            w_tdo = r_ir_sr[0];
        else if (r_state == S_SH_DR) begin
            if (w_sel_id)       w_tdo = r_id_sr[0];
            else if (w_sel_cfg) w_tdo = r_cfg_sr[0];
            else                w_tdo = r_bp_sr;
        end
    end

    always_ff @(negedge jtag_tck_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo    <= w_tdo;
            r_tdo_en <= (r_state == S_SH_IR) || (r_state == S_SH_DR);
        end
    end

    assign bus.jtag_tdo_o    = r_tdo;
    assign bus.jtag_tdo_en_o = r_tdo_en;
    assign bus.confreg_o     = r_confreg;
    assign bus.confreg_upd_o = r_confreg_upd;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: reset, IDCODE, bypass, CONFREG,
// soft reset, asynchronous reset mid-shift and undecoded opcodes.
module tb_jtag_tap_responder;

    logic tck;
    logic trst_n;
    int   n_chk;
    int   n_fail;

    jtag_tap_responder_if #(.CONFREG_WIDTH(9)) jif ();

    jtag_tap_responder dut (
        .jtag_tck_i   (tck),
        .jtag_trst_ni (trst_n),
        .bus          (jif)
    );

    initial begin
        tck = 1'b0;
        forever #10 tck = ~tck;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply TMS/TDI for one rising edge; return just after the following falling edge.
    task automatic tick(input logic tms, input logic tdi);
        jif.jtag_tms_i = tms;
        jif.jtag_tdi_i = tdi;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // Called in a Shift state; the last bit goes with TMS=1, ending in Exit1.
    task automatic shift(input int n, input logic [63:0] din,
                         output logic [63:0] dout, output int en_cnt);
        dout   = '0;
        en_cnt = 0;
        for (int i = 0; i < n; i++) begin
            dout[i] = jif.jtag_tdo_o;
            if (jif.jtag_tdo_en_o === 1'b1) en_cnt++;
            tick(i == n - 1, din[i]);
        end
    endtask

    task automatic goto_shdr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic finish_upd();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic load_ir(input logic [4:0] op, output logic [63:0] cap);
        int en;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        shift(5, {59'd0, op}, cap, en);
        finish_upd();
    endtask

    initial begin
        logic [63:0] dout;
        logic [63:0] cap;
        int          en;

        n_chk  = 0;
        n_fail = 0;
        trst_n = 1'b0;
        jif.jtag_tms_i = 1'b1;
        jif.jtag_tdi_i = 1'b0;

        // Reset state
        @(negedge tck);
        @(negedge tck);
        #1;
        chk("rst_confreg", 64'(jif.confreg_o), 64'h0);
        chk("rst_upd", 64'(jif.confreg_upd_o), 64'h0);
        chk("rst_tdo", 64'(jif.jtag_tdo_o), 64'h0);
        chk("rst_tdo_en", 64'(jif.jtag_tdo_en_o), 64'h0);
        trst_n = 1'b1;

        // IDCODE read straight after reset
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("capdr_tdo_en", 64'(jif.jtag_tdo_en_o), 64'h0);
        tick(1'b0, 1'b0);
        shift(32, 64'h0, dout, en);
        chk("idcode", dout, 64'h249511C3);
        chk("idcode_en_cnt", 64'(en), 64'd32);
        chk("ex1_tdo_en", 64'(jif.jtag_tdo_en_o), 64'h0);
        finish_upd();

        // IR capture and bypass
        load_ir(5'b11111, cap);
        chk("ir_capture", cap, 64'h01);
        goto_shdr();
        shift(9, 64'h0A5, dout, en);
        chk("bypass", dout, 64'h14A);
        finish_upd();

        // CONFREG write
        load_ir(5'b00110, cap);
        chk("ir_capture_cfg", cap, 64'h01);
        goto_shdr();
        shift(9, 64'h002, dout, en);
        chk("cfg_first_read", dout, 64'h0);
        chk("cfg_before_upd", 64'(jif.confreg_o), 64'h0);
        chk("upd_before_upd", 64'(jif.confreg_upd_o), 64'h0);
        tick(1'b1, 1'b0);
        chk("cfg_at_upd", 64'(jif.confreg_o), 64'h002);
        chk("upd_pulse", 64'(jif.confreg_upd_o), 64'h1);
        tick(1'b0, 1'b0);
        chk("upd_after", 64'(jif.confreg_upd_o), 64'h0);
        chk("cfg_after", 64'(jif.confreg_o), 64'h002);

        // Readback while writing zero
        goto_shdr();
        shift(9, 64'h000, dout, en);
        chk("cfg_readback", dout, 64'h002);
        finish_upd();
        chk("cfg_cleared", 64'(jif.confreg_o), 64'h0);

        // Restore 9'h002 for the soft-reset step
        goto_shdr();
        shift(9, 64'h002, dout, en);
        finish_upd();
        chk("cfg_rewrite", 64'(jif.confreg_o), 64'h002);

        // Soft reset from PauseDR
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("soft_rst_cfg", 64'(jif.confreg_o), 64'h002);
        chk("soft_rst_tdo_en", 64'(jif.jtag_tdo_en_o), 64'h0);
        tick(1'b0, 1'b0);
        goto_shdr();
        shift(32, 64'h0, dout, en);
        chk("soft_rst_idcode", dout, 64'h249511C3);
        finish_upd();

        // Asynchronous reset after 4 bits of a CONFREG shift
        load_ir(5'b00110, cap);
        goto_shdr();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        chk("mid_shift_en", 64'(jif.jtag_tdo_en_o), 64'h1);
        trst_n = 1'b0;
        #1;
        chk("arst_cfg", 64'(jif.confreg_o), 64'h0);
        chk("arst_upd", 64'(jif.confreg_upd_o), 64'h0);
        chk("arst_tdo_en", 64'(jif.jtag_tdo_en_o), 64'h0);
        chk("arst_tdo", 64'(jif.jtag_tdo_o), 64'h0);
        jif.jtag_tms_i = 1'b1;
        @(posedge tck);
        @(negedge tck);
        #1;
        chk("arst_upd_held", 64'(jif.confreg_upd_o), 64'h0);
        trst_n = 1'b1;
        tick(1'b0, 1'b0);
        goto_shdr();
        shift(32, 64'h0, dout, en);
        chk("arst_idcode", dout, 64'h249511C3);
        finish_upd();

        // Short CONFREG shift: 4 bits land in the top of the register
        load_ir(5'b00110, cap);
        goto_shdr();
        shift(4, 64'hB, dout, en);
        chk("short_read", dout, 64'h0);
        tick(1'b1, 1'b0);
        chk("short_cfg", 64'(jif.confreg_o), 64'h160);
        chk("short_upd", 64'(jif.confreg_upd_o), 64'h1);
        tick(1'b0, 1'b0);
        goto_shdr();
        shift(9, 64'h0, dout, en);
        chk("short_readback", dout, 64'h160);
        finish_upd();

        // Undecoded opcode behaves as BYPASS
        load_ir(5'b01010, cap);
        goto_shdr();
        shift(9, 64'h03C, dout, en);
        chk("undecoded_bypass", dout, 64'h078);
        finish_upd();
        chk("undecoded_cfg_kept", 64'(jif.confreg_o), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
